pixel_stream_decryptor: RTL and testbench
=========================================

// Module: pixel_stream_decryptor
// PURPOSE
//  Receiving end of the encrypted pixel stream. Takes encrypted 8-bit pixels over valid/ready and regenerates the
//  per-frame LFSR keystream the transmitter used. XORs each pixel with it and emits plaintext pixels with frame markers.
//  Sits between the pixel source (file reader / link) and the pixel_operator processing stage.
// PARAMETERS
//  IMG_W    320       pixels per row
//  IMG_H    320       rows per frame (320x320 = 102400 pixels)
//  LFSR_W   16        keystream LFSR width
//  TAPS     16'hB400  Galois feedback mask (right-shift form)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  key        in   16  frame seed; sampled only on key_load
//  key_load   in   1   1-cycle pulse: load seed, restart frame
//  in_valid   in   1   encrypted pixel valid
//  in_data    in   8   encrypted pixel
//  in_ready   out  1   decryptor can accept in_data
//  out_valid  out  1   decrypted pixel valid
//  out_data   out  8   decrypted pixel
//  out_ready  in   1   downstream accepts out_data
//  out_sof    out  1   qualifies out_data: first pixel of frame
//  out_eol    out  1   qualifies out_data: last pixel of a row
//  out_eof    out  1   qualifies out_data: last pixel of frame
//  frame_done out  1   1-cycle pulse when the eof beat hands off downstream
// BEHAVIOUR
//  Reset: state=IDLE, lfsr=0x0001, col=row=0. out_valid/out_data/out_sof/out_eol/out_eof/frame_done=0. in_ready=0.
//  FSM: IDLE (in_ready=0) -key_load-> RUN. RUN -last pixel accepted-> DRAIN. DRAIN -eof beat handed off-> RUN.
//   frame_done pulses on that handoff. The LFSR reseeds from the stored seed, so the keystream repeats every frame.
//  DRAIN: in_ready=0 until the eof beat leaves the output register.
//  Handshake: transfer on valid&&ready. RUN: in_ready = !out_valid || out_ready. Single output register, latency 1.
//   A stalled output holds out_data and the markers stable.
//  Keystream: ks = lfsr[7:0] before the step. out_data = in_data ^ ks. One LFSR step per accepted pixel:
//   lfsr <= lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
//  Counters: col 0..IMG_W-1, row 0..IMG_H-1, advanced per accepted pixel. col wraps to 0 with row+1.
//   At col=IMG_W-1,row=IMG_H-1 both wrap to 0.
//  Markers: sof = (col==0&&row==0); eol = (col==IMG_W-1); eof = eol&&(row==IMG_H-1). All captured with the pixel.
//  key_load, in any state and mid-frame included:
//   - seed <= key; lfsr <= key, or 0x0001 if key==0 (avoids LFSR lock-up).
//   - col=row=0, out_valid=0, pending output dropped; next state RUN.
//   - An in_data beat in the same cycle is not accepted (in_ready forced 0 that cycle).
//  Async reset mid-frame: everything returns to reset values immediately; the partial frame is lost.
// CONFIGURATION
//  PIXEL_DEC_CHKSUM_EN defined:
//   - adds output port frame_sum[15:0]: modulo-2^16 sum of all decrypted pixels of the frame.
//   - frame_sum updates on the frame_done cycle and holds until the next one.
//   - accumulator clears on reset, on key_load, and after each frame_done.
//  Macro undefined: no port, no accumulator.
// STRUCTURE
//  Package pixel_crypt_pkg:
//   - FSM state encoding (IDLE/RUN/DRAIN)
//   - default IMG_W/IMG_H
//   - LFSR_TAPS constant
//   - zero-seed substitute 16'h0001
//   Shared with the transmitter-side encryptor.
//  Sub-module lfsr_keystream: seed load, step enable, ks byte out. Reused by the encryptor.
// TESTING
//  1 key=0xACE1, key_load; in 0x00,0x00,0x00 -> out 0xE1 (sof=1),0x70,0x38; each 1 cycle after accept.
//  2 same stream, out_ready low 3 cycles on 2nd beat -> out_data 0x70 held; in_ready=0; no pixel lost/duplicated.
//  3 IMG_W=4,IMG_H=2, 8 beats:
//     eol on beats 4 and 8; eof on beat 8; frame_done 1 cycle after the beat-8 handoff.
//     beat 9 sof=1, decrypts with ks 0xE1 again.
//  4 key=0x0000, key_load; in 0x55 -> out 0x54 (seed forced 0x0001, ks=0x01).
//  5 key_load at beat 3 of frame with out_valid=1 -> output dropped; next accepted beat sof=1, ks restarts at seed.
//  6 rst_n low mid-frame (async, between edges) -> all outputs 0 at once; in_ready=0 until key_load.
//     With PIXEL_DEC_CHKSUM_EN, case 3 plaintext 1..8 -> frame_sum=0x0024.

Source files
------------

// File: rtl/pixel_crypt_pkg.sv
// Shared definitions for the pixel stream encryptor/decryptor pair:
// FSM encoding, default image geometry and LFSR keystream constants.
package pixel_crypt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 320;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

endpackage

// File: rtl/lfsr_keystream.sv
// Galois LFSR keystream generator: holds the frame seed, restarts from it on
// demand and steps once per enabled cycle. Shared with the encryptor side.
module lfsr_keystream
    import pixel_crypt_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              restart,
    input  logic              step,
    output logic [7:0]        ks
);

    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        seed_d = seed_q;
        lfsr_d = lfsr_q;
        if (seed_load) begin
            // an all-zero state would never leave zero
            seed_d = (seed_in == '0) ? LFSR_W'(ZERO_SEED_SUB) : seed_in;
            lfsr_d = seed_d;
        end else if (restart) begin
            lfsr_d = seed_q;
        end else if (step) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= LFSR_W'(ZERO_SEED_SUB);
            lfsr_q <= LFSR_W'(ZERO_SEED_SUB);
        end else begin
            seed_q <= seed_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign ks = lfsr_q[7:0];

endmodule

// File: rtl/pixel_stream_decryptor.sv
// Decrypts an LFSR-XOR encrypted pixel stream and tags frame markers.
// Optional per-frame plaintext checksum port enabled by PIXEL_DEC_CHKSUM_EN.
module pixel_stream_decryptor
    import pixel_crypt_pkg::*;
#(
    parameter int                IMG_W  = DEF_IMG_W,
    parameter int                IMG_H  = DEF_IMG_H,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] key,
    input  logic              key_load,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done
`ifdef PIXEL_DEC_CHKSUM_EN
    ,
    output logic [15:0]       frame_sum
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eol_q, out_eol_d;
    logic          out_eof_q, out_eof_d;
    logic          frame_done_q, frame_done_d;

    logic [7:0] ks;
    logic [7:0] plain;
    logic       accept;
    logic       handoff;
    logic       last_col;
    logic       last_row;

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !key_load;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign plain    = in_data ^ ks;

    // frame end rewinds the keystream so every frame reuses the same seed
    lfsr_keystream #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_keystream (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (key_load),
        .seed_in   (key),
        .restart   (accept && last_col && last_row),
        .step      (accept),
        .ks        (ks)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        frame_done_d = 1'b0;

        if (handoff) begin
            out_valid_d = 1'b0;
            if (out_eof_q) begin
                frame_done_d = 1'b1;
                state_d      = ST_RUN;
            end
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = plain;
            out_sof_d   = (col_q == '0) && (row_q == '0);
            out_eol_d   = last_col;
            out_eof_d   = last_col && last_row;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (last_col && last_row) state_d = ST_DRAIN;
        end

        if (key_load) begin
            state_d     = ST_RUN;
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign frame_done = frame_done_q;

`ifdef PIXEL_DEC_CHKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (accept) acc_d = acc_q + {8'd0, plain};
        if (handoff && out_eof_q) begin
            frame_sum_d = acc_q;
            acc_d       = '0;
        end
        if (key_load) acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_pixel_stream_decryptor.sv
// Self-checking bench for pixel_stream_decryptor: directed cases plus random
// traffic against a transaction-level model (4x2 frames to keep frames short).
module tb_pixel_stream_decryptor;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key = '0;
    logic        key_load = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;
`ifdef PIXEL_DEC_CHKSUM_EN
    logic [15:0] frame_sum;
`endif

    always #5 clk = ~clk;

    pixel_stream_decryptor #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_load   (key_load),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
`ifdef PIXEL_DEC_CHKSUM_EN
        ,
        .frame_sum  (frame_sum)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // model: keystream table for the current seed, linear pixel index in frame
    logic [7:0]  ks_tab [N];
    int          m_idx;
    bit          m_started, m_draining;
    logic        m_valid, m_sof, m_eol, m_eof, m_fd;
    logic [7:0]  m_data;
    logic [15:0] m_acc, m_sum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ks_at(input logic [15:0] seed, input int k);
        logic [15:0] l;
        l = (seed == 16'h0) ? 16'h0001 : seed;
        for (int s = 0; s < k; s++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l[7:0];
    endfunction

    function automatic logic exp_ready();
        return m_started && !m_draining && (!m_valid || out_ready) && !key_load;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_started = 0; m_draining = 0;
        m_valid = 0; m_sof = 0; m_eol = 0; m_eof = 0; m_fd = 0;
        m_data = '0; m_acc = '0; m_sum = '0;
        for (int k = 0; k < N; k++) ks_tab[k] = ks_at(16'h0001, k);
    endtask

    task automatic model_edge();
        logic rdy, acc, hand;
        logic [7:0] plain;
        rdy  = exp_ready();
        acc  = in_valid && rdy;
        hand = m_valid && out_ready;
        m_fd = 0;
        if (hand) begin
            m_valid = 0;
            if (m_eof) begin
                m_fd = 1; m_sum = m_acc; m_acc = '0; m_draining = 0;
            end
        end
        if (acc) begin
            plain   = in_data ^ ks_tab[m_idx];
            m_valid = 1;
            m_data  = plain;
            m_sof   = (m_idx == 0);
            m_eol   = ((m_idx % W) == W - 1);
            m_eof   = (m_idx == N - 1);
            m_acc   = m_acc + {8'd0, plain};
            if (m_eof) m_draining = 1;
            m_idx = (m_idx + 1) % N;
        end
        if (key_load) begin
            for (int k = 0; k < N; k++) ks_tab[k] = ks_at(key, k);
            m_idx = 0; m_valid = 0; m_started = 1; m_draining = 0; m_acc = '0;
        end
    endtask

    task automatic compare();
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        chk("frame_done", frame_done, m_fd);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_sof", out_sof, m_sof);
            chk("out_eol", out_eol, m_eol);
            chk("out_eof", out_eof, m_eof);
        end
`ifdef PIXEL_DEC_CHKSUM_EN
        chk("frame_sum", frame_sum, m_sum);
`endif
    endtask

    task automatic drive(input logic kl, input logic [15:0] k, input logic v,
                         input logic [7:0] d, input logic r);
        @(negedge clk);
        key_load = kl; key = k; in_valid = v; in_data = d; out_ready = r;
        #1;
        compare();
    endtask

    task automatic commit();
        @(posedge clk);
        model_edge();
    endtask

    task automatic cyc(input logic kl, input logic [15:0] k, input logic v,
                       input logic [7:0] d, input logic r);
        drive(kl, k, v, d, r);
        commit();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 1, 8'h12, 1);

        // 1: basic keystream
        cyc(1, 16'hACE1, 0, 0, 1);
        chk("model_ks0", ks_tab[0], 8'hE1);
        chk("model_ks1", ks_tab[1], 8'h70);
        cyc(0, 0, 1, 8'h00, 1);
        drive(0, 0, 1, 8'h00, 1);
        chk("t1_b1", out_data, 8'hE1);
        chk("t1_sof", out_sof, 1);
        commit();
        drive(0, 0, 1, 8'h00, 1);
        chk("t1_b2", out_data, 8'h70);
        commit();
        drive(0, 0, 0, 8'h00, 1);
        chk("t1_b3", out_data, 8'h38);
        commit();

        // 2: output stall
        cyc(1, 16'hACE1, 0, 0, 1);
        cyc(0, 0, 1, 8'h00, 1);
        cyc(0, 0, 1, 8'h00, 1);
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, 1, 8'h00, 0);
            chk("t2_hold", out_data, 8'h70);
            chk("t2_in_ready", in_ready, 0);
            commit();
        end
        cyc(0, 0, 1, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        chk("t2_b3", out_data, 8'h38);
        commit();

        // 3: full frame, plaintext 1..8
        cyc(1, 16'hACE1, 0, 0, 1);
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 1, 8'(i + 1) ^ ks_tab[i], 1);
            if (i == 4) begin
                chk("t3_eol4", out_eol, 1);
                chk("t3_eof4", out_eof, 0);
            end
            commit();
        end
        drive(0, 0, 1, 8'h00, 1);
        chk("t3_eol8", out_eol, 1);
        chk("t3_eof8", out_eof, 1);
        chk("t3_drain_rdy", in_ready, 0);
        commit();
        drive(0, 0, 0, 8'h00, 1);
        chk("t3_frame_done", frame_done, 1);
`ifdef PIXEL_DEC_CHKSUM_EN
        chk("t3_frame_sum", frame_sum, 16'h0024);
`endif
        commit();
        cyc(0, 0, 1, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        chk("t3_b9", out_data, 8'hE1);
        chk("t3_b9_sof", out_sof, 1);
        commit();

        // 4: zero key
        cyc(1, 16'h0000, 0, 0, 1);
        cyc(0, 0, 1, 8'h55, 1);
        drive(0, 0, 0, 8'h00, 1);
        chk("t4_zero_key", out_data, 8'h54);
        commit();

        // 5: key_load mid-frame with pending output
        cyc(1, 16'hACE1, 0, 0, 1);
        cyc(0, 0, 1, 8'h00, 1);
        cyc(0, 0, 1, 8'h00, 1);
        drive(1, 16'hACE1, 1, 8'h00, 0);
        chk("t5_kl_rdy", in_ready, 0);
        commit();
        drive(0, 0, 0, 8'h00, 1);
        chk("t5_dropped", out_valid, 0);
        commit();
        cyc(0, 0, 1, 8'h00, 1);
        drive(0, 0, 0, 8'h00, 1);
        chk("t5_restart", out_data, 8'hE1);
        chk("t5_sof", out_sof, 1);
        commit();

        // 6: async reset mid-frame
        cyc(1, 16'h1234, 0, 0, 1);
        cyc(0, 0, 1, 8'hA5, 1);
        cyc(0, 0, 1, 8'h5A, 0);
        #3;
        rst_n = 1'b0;
        key_load = 0; in_valid = 0; out_ready = 0;
        model_reset();
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_markers", {out_sof, out_eol, out_eof, frame_done}, 0);
        chk("t6_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, 1, 8'h33, 1);
            chk("t6_idle_rdy", in_ready, 0);
            commit();
        end
        cyc(1, 16'hBEEF, 0, 0, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic kl;
            logic [15:0] k;
            kl = ($urandom_range(0, 99) == 0);
            k  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cyc(kl, k, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
